// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier
//   Radix-2 shift-add multiplier that retires one partial product per clock.
//   Signed operands are reduced to magnitudes at start and the sign is
//   reapplied once, when the final product is registered.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          asynchronous reset, active high
//   start_i        operation request, honoured only while idle
//   signed_mode_i  1 = two's complement operands/product, 0 = unsigned
//   a_i, b_i       multiplicand / multiplier, captured with start_i
//   busy_o         operation in progress
//   done_o         one-cycle pulse, p_o valid from this cycle
//   p_o            registered 2*WIDTH product, held until the next done_o
//
// state | meaning
// IDLE  | waiting for start_i; p_o holds the last result
// RUN   | one shift-add iteration per clock, WIDTH iterations in total
module seq_shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 signed_mode_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   p_o
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     p_q, p_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [CW-1:0]     count_q, count_d;
    logic              neg_q, neg_d;
    logic              done_q, done_d;

    logic [WIDTH-1:0]  mag_a, mag_b;
    logic [PW-1:0]     acc_sum;

    // Negating the most negative value wraps back to 2^(WIDTH-1), which is
    // exactly the magnitude when read as an unsigned WIDTH-bit number.
    assign mag_a = (signed_mode_i && a_i[WIDTH-1]) ? (~a_i + WIDTH'(1)) : a_i;
    assign mag_b = (signed_mode_i && b_i[WIDTH-1]) ? (~b_i + WIDTH'(1)) : b_i;

    // The multiplicand is kept pre-shifted, so each step adds it directly
    // instead of shifting by count.
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            p_q      <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            p_q      <= p_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        p_d      = p_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        neg_d    = neg_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mcand_d  = {{WIDTH{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    neg_d    = signed_mode_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                if (count_q == LAST) begin
                    // A zero magnitude negates to zero, so no negative zero.
                    p_d     = neg_q ? (~acc_sum + PW'(1)) : acc_sum;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q == RUN);
    assign done_o = done_q;
    assign p_o    = p_q;

endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
- Parametrised sequential multiplier: radix-2 shift-add, one partial product per clock.
- Replaces fixed-width combinational array multipliers where area matters more than latency.
- Adds per-operation signed (two's complement) / unsigned mode, start/busy/done handshake and a registered product.
- Sits on the datapath as a shared arithmetic unit driven by a controller.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32; product width is 2*WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- signed_mode  input  1  1 = operands and product are two's complement, 0 = unsigned; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse; p is valid from this cycle.
- p  output  2*WIDTH  registered product; held until the next done.

Behaviour:
- Reset (async, active-high): state=IDLE, busy=0, done=0, p=0, internal accumulator, operand registers and counter cleared. Reset asserted mid-operation aborts it; no done is produced.
- States: IDLE, RUN.
- IDLE: busy=0. On an edge with start=1:
  - Latch mode and operand magnitudes: |a| and |b| in signed mode, raw values otherwise.
  - Latch sign flag neg = signed_mode & (a[MSB] ^ b[MSB]).
  - Clear the 2*WIDTH accumulator; count=0; go to RUN.
- RUN: busy=1. Each edge:
  - If the multiplier LSB is 1, add the multiplicand, shifted left by count, into the accumulator.
  - Shift the multiplier right by one; count increments.
  - The edge with count=WIDTH-1 performs the last iteration. At that edge:
    - p is loaded with the final accumulator, two's-complement negated if neg=1, truncated to 2*WIDTH bits.
    - done is set to 1.
    - State returns to IDLE.
- Latency: start sampled at edge k; iterations at edges k+1..k+WIDTH; busy high in cycles after edges k..k+WIDTH-1; done high for exactly the one cycle after edge k+WIDTH.
- done clears on the following edge unless that edge completes another operation.
- start while busy=1 is ignored; operands are not re-latched and the operation in flight is unaffected.
- Back-to-back: start may be asserted in the done cycle (state is IDLE) and is accepted. The next result follows WIDTH+1 edges later; p holds the old value until then.
- Input changes on a, b or signed_mode after the start edge have no effect.
- Width rules:
  - Magnitudes use WIDTH unsigned bits. The most negative operand, -2^(WIDTH-1), has magnitude 2^(WIDTH-1) and must be handled exactly.
  - The accumulator never overflows 2*WIDTH bits.
  - The signed product of two most-negative operands is +2^(2*WIDTH-2).
- Zero operand: product 0; neg is forced 0 by the result, with no negative zero.

Test Plan:
- WIDTH=8, unsigned, a=255, b=255, start for 1 cycle -> busy for 8 cycles, done pulse 9 edges after start, p=16'hFE01; p still 16'hFE01 ten cycles later.
- WIDTH=8, signed:
  - a=-128, b=-128 -> p=16'h4000.
  - a=-128, b=127 -> p=16'hC080.
  - a=-1, b=1 -> p=16'hFFFF.
  - a=0, b=-77 -> p=16'h0000.
- WIDTH=8, unsigned a=200, b=3 started; start re-asserted every cycle during busy with a=1, b=1 -> exactly one done, p=600 (16'h0258). Then start in the done cycle with a=7, b=9 -> next done 9 edges later, p=63.
- WIDTH=8, start unsigned a=15, b=15; assert rst asynchronously 4 cycles later, mid-cycle -> busy, done and p go to 0 immediately, no done pulse afterwards. After release, a new operation with a=15, b=15 gives p=225.
- WIDTH=4, exhaustive: all 256 operand pairs in both modes -> p matches the behavioural model (a*b unsigned, $signed(a)*$signed(b) signed), done latency always 5 edges.
- WIDTH=16, randomized 10k operations with random start gaps and 1% random resets -> every p matches the model, and exactly one done per accepted, unaborted start.
